serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder stepped LSB first, one bit per clock.
// IDLE latches operands on start, ADD walks WIDTH bits, DONE pulses for a single cycle.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             carry_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int IDXW = $clog2(WIDTH);
  localparam int CNTW = IDXW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic              r_cout;
  logic [CNTW-1:0]   r_cnt;
  logic [IDXW-1:0]   w_idx;
  logic              w_last;
  logic              w_fa_s;
  logic              w_fa_c;

  // The counter carries one spare bit so it can reach WIDTH without wrapping.
  assign w_idx  = r_cnt[IDXW-1:0];
  assign w_last = (r_cnt == CNTW'(WIDTH - 1));

  full_adder u_fa (
    .i_a    (r_a[w_idx]),
    .i_b    (r_b[w_idx]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_s),
    .o_cout (w_fa_c)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADD;
      S_ADD:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == S_IDLE);
    busy  = (r_state == S_ADD);
    done  = (r_state == S_DONE);
  end

  // Result bits land directly in the output register, so sum only moves during ADD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= operand_A;
            r_b     <= operand_B;
            r_carry <= carry_in;
            r_cnt   <= '0;
          end
        end
        S_ADD: begin
          r_sum[w_idx] <= w_fa_s;
          r_carry      <= w_fa_c;
          r_cnt        <= r_cnt + CNTW'(1);
          if (w_last) r_cout <= w_fa_c;
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver queues expected results, monitor checks each done.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand_A (a),
    .operand_B (b),
    .carry_in  (cin),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W:0] res;
    int         c;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   done_cnt  = 0;
  int   last_done = -1;
  int   prev_done = -1;
  bit   mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: status decode every cycle, result and latency on every done.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("status_onehot", 32'($countones({ready, busy, done})), 32'd1);
      if (done === 1'b1) begin
        exp_t e;
        done_cnt++;
        prev_done = last_done;
        last_done = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("result", 32'({cout, sum}), 32'(e.res));
          chk("latency", 32'(cyc - e.c), 32'(W + 1));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Called at a negedge; start is held for exactly one cycle, then operands are scrambled.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    exp_t e;
    wait_ready();
    a = ia; b = ib; cin = ic; start = 1'b1;
    e.res = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    e.c   = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int d0;
    int n;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    mon_en = 1'b1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_cout",  32'(cout),  32'd0);

    issue(8'h5A, 8'h3C, 1'b0);
    wait_drain();
    chk("d1_sum", 32'(sum), 32'h96);
    chk("d1_cout", 32'(cout), 32'd0);
    issue(8'hFF, 8'h01, 1'b0);
    wait_drain();
    chk("d2_sum", 32'(sum), 32'h00);
    chk("d2_cout", 32'(cout), 32'd1);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_drain();
    chk("d3_sum", 32'(sum), 32'hFF);
    chk("d3_cout", 32'(cout), 32'd1);

    // start held through the whole operation, operands changed mid-way
    d0 = done_cnt;
    wait_ready();
    begin
      exp_t e;
      a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
      e.res = 9'h097; e.c = cyc;
      q.push_back(e);
    end
    repeat (3) @(negedge clk);
    a = 8'hC3; b = 8'h77; cin = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_start_pulses", 32'(done_cnt - d0), 32'd1);
    chk("held_start_sum", 32'(sum), 32'h97);
    chk("held_start_queue", 32'(q.size()), 32'd0);
    q.delete();

    // reset in the middle of ADD
    d0 = done_cnt;
    issue(8'hAB, 8'hCD, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_sum",   32'(sum),   32'd0);
    chk("abort_cout",  32'(cout),  32'd0);
    repeat (14) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // back-to-back
    d0 = done_cnt;
    issue(8'h01, 8'h01, 1'b0);
    issue(8'h80, 8'h80, 1'b0);
    wait_drain();
    chk("b2b_pulses", 32'(done_cnt - d0), 32'd2);
    chk("b2b_spacing", 32'(last_done - prev_done), 32'd10);
    chk("b2b_sum", 32'(sum), 32'h00);
    chk("b2b_cout", 32'(cout), 32'd1);

    // randomized traffic with occasional idle gaps
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0) repeat ($urandom_range(12)) @(negedge clk);
    end
    wait_drain();
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
